// File: rtl/serial_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_rx_pkg                                              |
// | Brief   : Shared constants and state encoding for the serial receiver|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package serial_rx_pkg;

    localparam int c_DATA_W   = 32;
    localparam int c_MIN_BITS = c_DATA_W;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RECV = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_RECV = c_ST_RECV,
        ST_DONE = c_ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_rx_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync_edge                                                  |
// | Brief   : Multi-flop input synchronizer with rise/fall detection     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic r_prev;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= r_chain[STAGES-1];
                end
            end

            assign rise = r_chain[STAGES-1] & ~r_prev;
            assign fall = ~r_chain[STAGES-1] & r_prev;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : serial_rx                                                  |
// | Brief   : Oversampling MSB-first serial word receiver                |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              data_enable,
    input  logic              sdi,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_error,
    output logic              rx_busy,
    output logic [CNT_W-1:0]  bit_count
);

    localparam logic [CNT_W-1:0] c_MIN_CNT = CNT_W'(DATA_W);

    logic w_sclk_rise;
    logic w_en_q;
    logic w_en_rise;
    logic w_en_fall;
    logic w_sdi_q;

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .q     (),
        .rise  (w_sclk_rise),
        .fall  ()
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_en (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (data_enable),
        .q     (w_en_q),
        .rise  (w_en_rise),
        .fall  (w_en_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sdi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sdi),
        .q     (w_sdi_q),
        .rise  (),
        .fall  ()
    );

    state_t            r_state;
    state_t            w_state_next;
    logic              w_clear;
    logic              w_shift;
    logic              w_done_ok;
    logic              w_done_err;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_frame_error;
    logic [CNT_W-1:0]  r_bit_count;
    logic [SYNC_STAGES:0] r_warm;
    logic              r_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_done_ok    = 1'b0;
        w_done_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_en_rise && r_armed) begin
                    w_clear      = 1'b1;
                    w_state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                // an sclk edge coinciding with the enable fall is dropped
                if (w_en_fall) begin
                    w_state_next = ST_DONE;
                end else if (w_sclk_rise && w_en_q) begin
                    w_shift = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                if (r_bit_count >= c_MIN_CNT) begin
                    w_done_ok = 1'b1;
                end else begin
                    w_done_err = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift       <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_bit_count   <= '0;
            r_warm        <= '0;
            r_armed       <= 1'b0;
        end else begin
            r_data_valid  <= w_done_ok;
            r_frame_error <= w_done_err;
            r_warm        <= {r_warm[SYNC_STAGES-1:0], 1'b1};
            // a frame already in progress at reset release must not be picked up
            if (r_warm[SYNC_STAGES] && !w_en_q) begin
                r_armed <= 1'b1;
            end
            if (w_clear) begin
                r_shift     <= '0;
                r_bit_count <= '0;
            end else if (w_shift) begin
                r_shift <= {r_shift[DATA_W-2:0], w_sdi_q};
                if (r_bit_count != {CNT_W{1'b1}}) begin
                    r_bit_count <= r_bit_count + 1'b1;
                end
            end
            if (w_done_ok) begin
                r_data_out <= r_shift;
            end
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign rx_busy     = (r_state == ST_RECV);
    assign bit_count   = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_serial_rx                                               |
// | Brief   : Randomized self-checking bench for serial_rx               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_serial_rx;

    localparam int DATA_W      = 32;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 6;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              sclk;
    logic              data_enable;
    logic              sdi;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_error;
    logic              rx_busy;
    logic [CNT_W-1:0]  bit_count;

    serial_rx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .data_enable (data_enable),
        .sdi         (sdi),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .rx_busy     (rx_busy),
        .bit_count   (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          cnt;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         got_q[$];
    int          n_checks;
    int          n_fail;
    int          n_viol;
    logic [31:0] model_word;
    int          model_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // pulse recorder: every valid/error pulse is logged with the outputs at that moment
    initial begin
        bit prev_v;
        bit prev_e;
        prev_v = 1'b0;
        prev_e = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (data_valid || frame_error)
                got_q.push_back('{frame_error, data_out, int'(bit_count)});
            if (data_valid && frame_error) n_viol++;
            if ((data_valid && prev_v) || (frame_error && prev_e)) n_viol++;
            prev_v = data_valid;
            prev_e = frame_error;
        end
    end

    // reference: bits are sent from index n-1 down to 0, so the last 32 sent are bits[31:0]
    task automatic model_frame(input logic [127:0] bits, input int n);
        int cnt;
        cnt = (n > CNT_MAX) ? CNT_MAX : n;
        if (n >= DATA_W) begin
            model_word = bits[31:0];
            exp_q.push_back('{1'b0, model_word, cnt});
        end else begin
            exp_q.push_back('{1'b1, model_word, cnt});
        end
        model_cnt = cnt;
    endtask

    task automatic send_bit(input logic b);
        sdi  = b;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [127:0] bits, input int n);
        data_enable = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i]);
            if (i == n - 1) check("rx_busy_in_frame", rx_busy, 1);
        end
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        data_enable = 1'b0;
    endtask

    task automatic run_frame(input logic [127:0] bits, input int n);
        model_frame(bits, n);
        send_frame(bits, n);
    endtask

    task automatic flush_check(input string tag);
        int n;
        repeat (12) @(negedge clk);
        check({tag, "_num_pulses"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_kind"},  got_q[i].is_err, exp_q[i].is_err);
            check({tag, "_data"},  got_q[i].data,   exp_q[i].data);
            check({tag, "_count"}, got_q[i].cnt,    exp_q[i].cnt);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [127:0] bits;
        logic [31:0]  word;
        int           lat;
        int           n;

        n_checks    = 0;
        n_fail      = 0;
        n_viol      = 0;
        model_word  = '0;
        model_cnt   = 0;
        rst_n       = 1'b0;
        sclk        = 1'b0;
        data_enable = 1'b0;
        sdi         = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_data_out",    data_out,    0);
        check("reset_data_valid",  data_valid,  0);
        check("reset_frame_error", frame_error, 0);
        check("reset_rx_busy",     rx_busy,     0);
        check("reset_bit_count",   bit_count,   0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // 33-bit frame: MSB repeated, then the full word
        bits = {95'd0, 1'b1, 32'hDEADBEEF};
        run_frame(bits, 33);
        flush_check("deadbeef_33");

        // exact 32-bit frame with latency measured from the pin fall
        bits = {96'd0, 32'h12345678};
        model_frame(bits, 32);
        send_frame(bits, 32);
        lat = 0;
        while (!data_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("valid_latency", lat, SYNC_STAGES + 2);
        flush_check("word_12345678");

        // good frame followed by a short one
        run_frame({96'd0, 32'hA5A5A5A5}, 32);
        flush_check("good_a5");
        bits = {$urandom, $urandom, $urandom, $urandom};
        run_frame(bits, 10);
        flush_check("short_10");
        check("short_data_hold", data_out, 32'hA5A5A5A5);
        check("short_bit_count", bit_count, 10);

        // reset in the middle of a frame
        word = 32'hCAFEBABE;
        data_enable = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 31; i >= 16; i--) send_bit(word[i]);
        sdi  = word[15];
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data_out",    data_out,    0);
        check("midrst_data_valid",  data_valid,  0);
        check("midrst_frame_error", frame_error, 0);
        check("midrst_rx_busy",     rx_busy,     0);
        check("midrst_bit_count",   bit_count,   0);
        model_word = '0;
        model_cnt  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 15; i >= 0; i--) send_bit(word[i]);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        data_enable = 1'b0;
        flush_check("after_rst_partial");
        check("after_rst_busy_idle", rx_busy, 0);
        run_frame({96'd0, 32'h0F0F0F0F}, 32);
        flush_check("word_0f0f");

        // sclk activity with the enable low
        for (int i = 0; i < 40; i++) begin
            sclk = ~sclk;
            sdi  = 1'($urandom);
            repeat (2) @(negedge clk);
        end
        sclk = 1'b0;
        check("idle_sclk_bit_count", bit_count, model_cnt);
        check("idle_sclk_rx_busy",   rx_busy,   0);
        check("idle_sclk_data_out",  data_out,  model_word);
        flush_check("idle_sclk");

        // back-to-back frames with a two-cycle enable gap
        run_frame({96'd0, 32'h00000001}, 32);
        repeat (2) @(negedge clk);
        run_frame({96'd0, 32'hFFFFFFFF}, 32);
        flush_check("back_to_back");

        // counter saturation on an overlong frame
        bits = {$urandom, $urandom, $urandom, $urandom};
        run_frame(bits, 66);
        flush_check("long_66");

        // random frame lengths around the word boundary
        for (int k = 0; k < 8; k++) begin
            bits = {$urandom, $urandom, $urandom, $urandom};
            n    = int'($urandom_range(0, 45));
            run_frame(bits, n);
            flush_check("random");
        end

        check("pulse_rules", n_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Receive side of the 32-bit serial link: MSB-first data, framed by an active-high data enable (chip select), shifted out on sclk falling edges.
- Runs on the system clock and oversamples the serial signals. Recovers each word and presents it in parallel with a one-cycle valid pulse.
- Sits between the serial pins and the calculator core's operand/result registers.

Parameters:
- DATA_W, 32, word width and minimum bits per valid frame
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2)
- CNT_W, 6, bit-counter width; counter saturates at 2^CNT_W-1

Ports:
- clk  input  1  system clock; must run at least 4x sclk frequency
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  serial clock from transmitter, asynchronous to clk
- data_enable  input  1  frame enable / chip select, active high, asynchronous
- sdi  input  1  serial data in, MSB first
- data_out  output  DATA_W  last received word, held until next good frame
- data_valid  output  1  one-clk pulse: data_out updated
- frame_error  output  1  one-clk pulse: frame ended with fewer than DATA_W bits
- rx_busy  output  1  high while in RECV state
- bit_count  output  CNT_W  bits sampled in current/last frame

Behaviour:
- Reset (async assert, sync release): data_out=0, data_valid=0, frame_error=0, rx_busy=0, bit_count=0, shift register=0, state=IDLE, synchronizer chains=0.
- Synchronize sclk, data_enable and sdi through SYNC_STAGES flops each; keep one extra delayed copy of synced sclk and synced enable for edge detection.
- sclk_rise = synced sclk 1 and previous 0. en_rise and en_fall are defined the same way on synced enable.
- Sampling uses sclk rising edge, mid-bit relative to transmitter's falling-edge launch.
- FSM states IDLE, RECV, DONE:
  - IDLE: on en_rise, clear shift register and bit_count, go to RECV. sclk edges are ignored in IDLE.
  - RECV: rx_busy=1. On sclk_rise with synced enable high, shift left, insert synced sdi at LSB, bit_count+1 saturating at 2^CNT_W-1.
  - RECV on en_fall: go to DONE. A sclk_rise in the same cycle is discarded.
  - DONE, one cycle:
    - if bit_count >= DATA_W: data_out <= shift register low DATA_W bits, data_valid=1.
    - else frame_error=1 and data_out is unchanged.
    - Always return to IDLE.
- Frames longer than DATA_W are legal; the last DATA_W bits sampled are kept. A frame with the first bit repeated (DATA_W+1 bits) therefore decodes correctly.
- Latency: data_valid asserts SYNC_STAGES+2 clk cycles after data_enable falls at the pin.
- en_rise while in DONE is not possible; the enable must stay low at least 2 clk cycles between frames. If violated, the frame is lost without an error flag.
- Reset mid-frame: immediate return to IDLE. No valid or error pulse. A partial frame after reset release is ignored until the next en_rise.
- data_valid and frame_error are mutually exclusive and never asserted for more than one cycle.
- bit_count holds its final value after DONE until the next en_rise.

Decomposition:
- Shared package: DATA_W default, state encoding constants (IDLE=2'd0, RECV=2'd1, DONE=2'd2), and a minimum-bit constant.
- One natural sub-module, sync_edge: parameterized multi-flop synchronizer plus rise/fall detector. Instantiated three times (edge outputs unused for sdi).

Test Plan:
- 33-bit frame with bit31 sent twice, then 0xDEADBEEF bits 30..0, sclk = clk/8 -> data_out=0xDEADBEEF, data_valid one cycle, bit_count=33, frame_error=0.
- Exactly 32-bit frame of 0x12345678 -> data_out=0x12345678, data_valid pulse SYNC_STAGES+2 cycles after enable falls.
- 10-bit frame after a good 0xA5A5A5A5 frame -> frame_error pulse, data_out stays 0xA5A5A5A5, bit_count=10.
- rst_n pulsed low at bit 16 of a frame -> all outputs 0 immediately. Remainder of that frame produces no pulse. Next full frame of 0x0F0F0F0F decodes correctly.
- sclk toggling 40 times with data_enable low -> no state change, no pulses, bit_count unchanged.
- Back-to-back frames 0x00000001 then 0xFFFFFFFF with 2-clk enable gap -> two data_valid pulses with the respective values in order.
